batcharger_ctrl: RTL and testbench

Digital charge controller for the 64-bit battery charger macro. It sits directly upstream of the analog charger model. It consumes ADC conversions of battery voltage, battery current and the temperature-sense voltage, and runs the trickle (TC) / constant-current (CC) / constant-voltage (CV) / end-of-charge sequence. It drives the charger with one-hot mode flags plus current and voltage setpoint codes.

---
 rtl/batcharger_ctrl.sv | 141 ++++++++++++++
 tb/tb_batcharger_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/batcharger_ctrl.sv
// Charge controller: sequences trickle / constant-current / constant-voltage
// charging from ADC samples and drives registered mode flags and setpoints.
//
// Handshake: sample_valid is a one-cycle strobe with no back-pressure. The
// vbat/ibat/vtemp values are consumed on the same rising edge. Any state
// change caused by a sample, and all outputs that follow from it, are visible
// from that edge onward. en=0 overrides everything on the next edge.
module batcharger_ctrl #(
  parameter int unsigned CV_TMAX = 1024,
  parameter int unsigned VRECH   = 8
) (
  input  logic       clk,
  input  logic       rstz,
  input  logic       en,
  input  logic [3:0] sel,
  input  logic       sample_valid,
  input  logic [7:0] vbat,
  input  logic [7:0] ibat,
  input  logic [7:0] vtemp,
  input  logic [7:0] vcutoff,
  input  logic [7:0] vpreset,
  input  logic [7:0] tempmin,
  input  logic [7:0] tempmax,
  output logic       tc,
  output logic       cc,
  output logic       cv,
  output logic [7:0] ichg_code,
  output logic [7:0] vcv_code,
  output logic       done,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TC   = 3'd1,
    S_CC   = 3'd2,
    S_CV   = 3'd3,
    S_END  = 3'd4
  } state_t;

  localparam logic [15:0] CV_MAX  = 16'(CV_TMAX);
  localparam logic [7:0]  VRECH_C = 8'(VRECH);

  state_t      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] cv_cnt_q, cv_cnt_d;

  logic        temp_ok;
  logic        charging;
  logic [4:0]  cap_q_p1;
  logic [4:0]  cap_d_p1;
  logic [15:0] cv_cnt_inc;
  logic [7:0]  rech_thr;
  logic [7:0]  ichg_d;

  assign temp_ok    = (vtemp >= tempmin) && (vtemp <= tempmax);
  assign charging   = (state_q == S_TC) || (state_q == S_CC) || (state_q == S_CV);
  assign cap_q_p1   = {1'b0, sel_q} + 5'd1;
  assign cap_d_p1   = {1'b0, sel_d} + 5'd1;
  assign cv_cnt_inc = (cv_cnt_q >= CV_MAX) ? CV_MAX : cv_cnt_q + 16'd1;
  // Recharge threshold floors at zero when vpreset is below the hysteresis.
  assign rech_thr   = (vpreset > VRECH_C) ? (vpreset - VRECH_C) : 8'd0;
  assign dbg_state  = state_q;

  // Next-state, capacity latch and CV sample counter; one transition per sample.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cv_cnt_d = cv_cnt_q;
    if (!en) begin
      state_d = S_IDLE;
    end else if (sample_valid) begin
      if (charging && !temp_ok) begin
        state_d = S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (temp_ok && (vbat < vpreset)) begin
              sel_d   = sel;
              state_d = (vbat < vcutoff) ? S_TC : S_CC;
            end
          end
          S_TC: begin
            if (vbat >= vcutoff) state_d = S_CC;
          end
          S_CC: begin
            if (vbat >= vpreset) begin
              state_d  = S_CV;
              cv_cnt_d = 16'd0;
            end
          end
          S_CV: begin
            cv_cnt_d = cv_cnt_inc;
            if ((ibat < {3'b000, cap_q_p1}) || (cv_cnt_inc >= CV_MAX)) state_d = S_END;
          end
          S_END: begin
            if (vbat < rech_thr) state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Current setpoint follows the state being entered and the latched capacity.
  always_comb begin
    ichg_d = 8'd0;
    unique case (state_d)
      S_TC:    ichg_d = {3'b000, cap_d_p1};
      S_CC:    ichg_d = {cap_d_p1, 3'b000};
      S_CV:    ichg_d = {cap_d_p1, 3'b000};
      default: ichg_d = 8'd0;
    endcase
  end

  // State register with registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q   <= S_IDLE;
      sel_q     <= 4'd0;
      cv_cnt_q  <= 16'd0;
      tc        <= 1'b0;
      cc        <= 1'b0;
      cv        <= 1'b0;
      ichg_code <= 8'd0;
      vcv_code  <= 8'd0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cv_cnt_q  <= cv_cnt_d;
      tc        <= (state_d == S_TC);
      cc        <= (state_d == S_CC);
      cv        <= (state_d == S_CV);
      ichg_code <= ichg_d;
      vcv_code  <= (state_d == S_CV) ? vpreset : 8'd0;
      done      <= (state_d == S_END);
    end
  end

endmodule

// File: tb/tb_batcharger_ctrl.sv
// Bench for batcharger_ctrl: directed charge scenarios followed by random
// stimulus, all checked against a sample-level behavioural model.
module tb_batcharger_ctrl;

  localparam int CV_TMAX = 4;
  localparam int VRECH   = 8;

  localparam int M_IDLE = 0;
  localparam int M_TC   = 1;
  localparam int M_CC   = 2;
  localparam int M_CV   = 3;
  localparam int M_END  = 4;

  logic       clk = 1'b0;
  logic       rstz;
  logic       en;
  logic [3:0] sel;
  logic       sample_valid;
  logic [7:0] vbat, ibat, vtemp, vcutoff, vpreset, tempmin, tempmax;
  logic       tc, cc, cv, done;
  logic [7:0] ichg_code, vcv_code;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: mode, latched capacity index, CV samples taken.
  int m_st;
  int m_sel;
  int m_cv_samples;

  // Expected output word {tc,cc,cv,done,ichg[7:0],vcv[7:0]}.
  logic [19:0] exp_q[$];

  batcharger_ctrl #(.CV_TMAX(CV_TMAX), .VRECH(VRECH)) dut (
    .clk(clk), .rstz(rstz), .en(en), .sel(sel), .sample_valid(sample_valid),
    .vbat(vbat), .ibat(ibat), .vtemp(vtemp), .vcutoff(vcutoff), .vpreset(vpreset),
    .tempmin(tempmin), .tempmax(tempmax), .tc(tc), .cc(cc), .cv(cv),
    .ichg_code(ichg_code), .vcv_code(vcv_code), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_push();
    int ichg;
    ichg = 0;
    if (m_st == M_TC) ichg = m_sel + 1;
    if (m_st == M_CC || m_st == M_CV) ichg = 8 * (m_sel + 1);
    exp_q.push_back({m_st == M_TC, m_st == M_CC, m_st == M_CV, m_st == M_END,
                     8'(ichg), (m_st == M_CV) ? vpreset : 8'd0});
  endtask

  task automatic model_reset();
    m_st = M_IDLE;
    m_sel = 0;
    m_cv_samples = 0;
    model_push();
  endtask

  task automatic model_step();
    bit t_ok;
    int thr;
    if (!rstz) begin
      model_reset();
      return;
    end
    t_ok = (int'(vtemp) >= int'(tempmin)) && (int'(vtemp) <= int'(tempmax));
    if (!en) begin
      m_st = M_IDLE;
    end else if (sample_valid) begin
      if ((m_st == M_TC || m_st == M_CC || m_st == M_CV) && !t_ok) begin
        m_st = M_IDLE;
      end else begin
        case (m_st)
          M_IDLE: if (t_ok && int'(vbat) < int'(vpreset)) begin
            m_sel = int'(sel);
            m_st = (int'(vbat) < int'(vcutoff)) ? M_TC : M_CC;
          end
          M_TC: if (int'(vbat) >= int'(vcutoff)) m_st = M_CC;
          M_CC: if (int'(vbat) >= int'(vpreset)) begin
            m_st = M_CV;
            m_cv_samples = 0;
          end
          M_CV: begin
            m_cv_samples++;
            if (int'(ibat) < m_sel + 1 || m_cv_samples >= CV_TMAX) m_st = M_END;
          end
          M_END: begin
            thr = int'(vpreset) - VRECH;
            if (thr < 0) thr = 0;
            if (int'(vbat) < thr) m_st = M_IDLE;
          end
          default: m_st = M_IDLE;
        endcase
      end
    end
    model_push();
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic compare_all();
    logic [19:0] e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check("tc", 32'(tc), 32'(e[19]));
    check("cc", 32'(cc), 32'(e[18]));
    check("cv", 32'(cv), 32'(e[17]));
    check("done", 32'(done), 32'(e[16]));
    check("ichg_code", 32'(ichg_code), 32'(e[15:8]));
    check("vcv_code", 32'(vcv_code), 32'(e[7:0]));
    check("onehot", 32'(32'(tc) + 32'(cc) + 32'(cv) <= 1), 32'd1);
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive_sample(input logic [7:0] vb, input logic [7:0] ib, input logic [7:0] vt);
    @(negedge clk);
    vbat = vb;
    ibat = ib;
    vtemp = vt;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic async_reset();
    #2;
    rstz = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("rst_ichg", 32'(ichg_code), 32'd0);
    check("rst_flags", 32'({tc, cc, cv, done}), 32'd0);
    @(negedge clk);
    rstz = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstz = 1'b0; en = 1'b0; sel = 4'd0; sample_valid = 1'b0;
    vbat = 8'd0; ibat = 8'd0; vtemp = 8'd0; vcutoff = 8'd0; vpreset = 8'd0;
    tempmin = 8'd0; tempmax = 8'd0;
    #1;
    model_reset();
    compare_all();
    check("reset_vcv", 32'(vcv_code), 32'd0);
    step();
    step();
    @(negedge clk);
    rstz = 1'b1;
    sel = 4'b1000; vcutoff = 8'd100; vpreset = 8'd200;
    tempmin = 8'd50; tempmax = 8'd150; en = 1'b1;

    // Full charge sequence.
    drive_sample(8'd80, 8'd50, 8'd100);
    check("seq_tc", 32'(tc), 32'd1);
    check("seq_tc_ichg", 32'(ichg_code), 32'd9);
    for (int v = 90; v <= 210; v += 10) begin
      drive_sample(8'(v), 8'd50, 8'd100);
      if (v == 100) check("seq_cc_ichg", 32'(ichg_code), 32'd72);
      if (v == 200) check("seq_cv_vcv", 32'(vcv_code), 32'd200);
    end
    drive_sample(8'd210, 8'd9, 8'd100);
    check("seq_ibat9_not_done", 32'(done), 32'd0);
    drive_sample(8'd210, 8'd8, 8'd100);
    check("seq_done", 32'(done), 32'd1);

    // Recharge hysteresis.
    drive_sample(8'd193, 8'd50, 8'd100);
    check("rech_193_end", 32'(done), 32'd1);
    drive_sample(8'd191, 8'd50, 8'd100);
    check("rech_191_idle", 32'({tc, cc, cv, done}), 32'd0);
    drive_sample(8'd191, 8'd50, 8'd100);
    check("rech_cc", 32'(cc), 32'd1);

    // Capacity select is ignored once charging.
    sel = 4'd0;
    drive_sample(8'd191, 8'd50, 8'd100);
    check("sel_hold_ichg", 32'(ichg_code), 32'd72);

    // Temperature fault in CC, then recovery.
    drive_sample(8'd150, 8'd50, 8'd200);
    check("tfault_flags", 32'({tc, cc, cv}), 32'd0);
    check("tfault_ichg", 32'(ichg_code), 32'd0);
    drive_sample(8'd150, 8'd50, 8'd100);
    check("tfault_recc", 32'(cc), 32'd1);

    // CV timeout after CV_TMAX samples.
    drive_sample(8'd200, 8'd50, 8'd100);
    check("tmo_cv", 32'(cv), 32'd1);
    for (int k = 1; k <= CV_TMAX; k++) begin
      drive_sample(8'd205, 8'd50, 8'd100);
      check("tmo_done", 32'(done), 32'(k == CV_TMAX));
    end

    // en dropped mid-CV without a sample.
    drive_sample(8'd150, 8'd50, 8'd100);
    drive_sample(8'd150, 8'd50, 8'd100);
    drive_sample(8'd200, 8'd50, 8'd100);
    drive_sample(8'd200, 8'd50, 8'd100);
    check("endrop_in_cv", 32'(cv), 32'd1);
    @(negedge clk);
    en = 1'b0;
    step();
    check("endrop_idle", 32'({tc, cc, cv, done}), 32'd0);
    // A sample coinciding with en low is ignored.
    drive_sample(8'd150, 8'd50, 8'd100);
    check("en_low_sample", 32'(cc), 32'd0);
    en = 1'b1;

    // Reset mid-CC.
    drive_sample(8'd150, 8'd50, 8'd100);
    check("prerst_cc", 32'(cc), 32'd1);
    async_reset();
    step();

    // Random stimulus.
    for (int i = 0; i < 1500; i++) begin
      if (i % 250 == 0) begin
        vcutoff = 8'($urandom_range(0, 150));
        vpreset = ((i / 250) % 2 == 1) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(100, 255));
        tempmin = 8'($urandom_range(20, 80));
        tempmax = 8'($urandom_range(120, 200));
      end
      @(negedge clk);
      en = ($urandom_range(0, 19) != 0);
      sample_valid = ($urandom_range(0, 2) != 0);
      vbat = 8'($urandom_range(0, 255));
      ibat = 8'($urandom_range(0, 40));
      vtemp = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(90, 110));
      if ($urandom_range(0, 15) == 0) sel = 4'($urandom_range(0, 15));
      step();
      sample_valid = 1'b0;
      if ($urandom_range(0, 199) == 0) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
